lif_array: RTL and testbench
============================

# lif_array

Parametrised, time-multiplexed array of leaky integrate-and-fire neurons. It replaces the single 8-bit ramp/threshold neuron with N_CH independent channels, each with its own input current and threshold. Each channel has a true leaky membrane, saturation and a refractory period. Spikes are queued as timestamped events in an event FIFO with a valid/ready interface, which the downstream UART message formatter drains.

## Interface
- N_CH, 4: number of neuron channels (1..16).
- W, 8: input current width per channel.
- VW, 12: membrane potential and threshold width (VW > W).
- LEAK_SHIFT, 4: leak is v >> LEAK_SHIFT per tick.
- REFRACT, 2: refractory length in ticks after a spike (0 = none).
- TICK_DIV, 12000: clk cycles per neuron tick (must be > N_CH+1).
- TSW, 16: timestamp width.
- FIFO_DEPTH, 8: event FIFO entries (power of 2, ≥2).
- clk, in, 1: system clock.
- rst, in, 1: asynchronous, active-high reset.
- en, in, 1: enables the tick divider.
- cur_in, in, N_CH*W: packed input currents; channel k is at [k*W +: W].
- th_in, in, N_CH*VW: packed thresholds; 0 disables the channel.
- spike, out, N_CH: one-cycle spike pulse per channel.
- vmem_out, out, N_CH*VW: packed membrane potentials (registered).
- ev_valid, out, 1: FIFO non-empty.
- ev_ch, out, 4: channel index of the head event.
- ev_ts, out, TSW: tick timestamp of the head event.
- ev_ready, in, 1: consumer accepts the head event.
- ovf, out, 1: sticky overflow flag; set when an event is dropped.
- ovf_clr, in, 1: clears ovf.
- busy, out, 1: a scan is in progress.

## Operation
- **Tick divider:** counts while en=1. At count TICK_DIV-1 it wraps to 0, asserts an internal tick for one cycle and increments ts (wraps modulo 2^TSW). When en=0 the count holds at 0; an in-progress scan still completes.
- **Scan FSM:** states IDLE and SCAN.
  - IDLE → SCAN on tick; ch_idx = 0.
  - In SCAN, one channel is updated per cycle. After ch_idx = N_CH-1 the FSM returns to IDLE.
  - busy = (state == SCAN).
- **Channel update** for channel k (v, rcnt = refractory counter):
  - If th_k == 0: v = 0, rcnt = 0, no spike.
  - Else if rcnt != 0: v = 0, rcnt -= 1, no spike.
  - Else compute s = v - (v >> LEAK_SHIFT) + zero-extend(cur_k) in VW+1 bits, and vn = min(s, 2^VW - 1).
    - If vn >= th_k: spike, v = 0, rcnt = REFRACT.
    - Else v = vn.
- **Spike handling:** on a spike, spike[k] is registered high for one cycle, and {k, ts} is pushed into the FIFO.
- **FIFO:**
  - Pop when ev_valid && ev_ready.
  - A push is accepted when the FIFO is not full, or when a pop occurs in the same cycle.
  - Otherwise the event is dropped and ovf is set.
  - ovf_clr clears ovf; if a drop and ovf_clr occur in the same cycle, set wins.
  - ev_ch and ev_ts show the head entry; they are 0 when empty.
- **Reset:** asynchronous, takes effect at any point including mid-scan.
  - Outputs: spike=0, vmem_out=0, ev_valid=0, ev_ch=0, ev_ts=0, ovf=0, busy=0.
  - Internal: all v, rcnt, ts, the divider and the FIFO pointers are cleared; FSM = IDLE.

## Timing
- tick asserted in cycle T: ts increments at the end of T, so events from this scan carry the new ts. The first tick after reset gives ts = 1.
- Channel k is evaluated in cycle T+1+k.
- spike[k] and vmem_out[k] update at the end of that cycle, i.e. visible in cycle T+2+k.
- A pushed event makes ev_valid visible in T+2+k when the FIFO was empty.
- Simultaneous spikes are enqueued in ascending channel order, one per cycle.
- Pop is visible next cycle: the head advances, or ev_valid drops.
- cur_in and th_in are sampled in the channel's evaluation cycle.

## Test plan
Parameters: N_CH=4, W=8, VW=12, LEAK_SHIFT=4, REFRACT=2, TICK_DIV=16, FIFO_DEPTH=4.
- **Reset:** pulse rst mid-run.
  - Required: all outputs 0 asynchronously.
  - Required: first event after release has ts=1.
- **Leak:** cur0=100, th0=4095.
  - Required: vmem_out[0] = 100, 194, 282 after ticks 1, 2, 3; no spike.
- **Spike and refractory:** cur0=100, th0=250.
  - Required: tick 3 gives a spike[0] pulse; event {0, ts=3}; v=0.
  - Required: ticks 4 and 5 give v=0 and no spike.
  - Required: tick 6 gives v=100.
- **Simultaneous spikes:** all cur=255, th=200.
  - Required: tick 1 gives spike pulses on consecutive cycles for ch 0, 1, 2, 3.
  - Required: FIFO order ch 0, 1, 2, 3, all with ts=1.
- **Overflow:** same stimulus as the previous scenario, ev_ready=0 until tick 5.
  - Required: tick 4 events are dropped and ovf=1.
  - Required: draining returns the four ts=1 events.
  - Required: ovf_clr clears ovf.
  - Required: push and pop in the same cycle while full is accepted.
- **Disabled channel and en gating:**
  - Required: th2=0 with cur2=255 keeps v2=0 and produces no events.
  - Required: deasserting en mid-scan lets the scan finish, with no further ticks and ts held.

Source files
------------

// File: rtl/lif_array.sv
`default_nettype none
// ============================================================================
// Module   : lif_array
// Purpose  : Time-multiplexed leaky integrate-and-fire neuron array with a
//            timestamped spike event FIFO (valid/ready drain side).
// Revision : 1.0 - initial release
// ============================================================================
module lif_array #(
  parameter int N_CH       = 4,
  parameter int W          = 8,
  parameter int VW         = 12,
  parameter int LEAK_SHIFT = 4,
  parameter int REFRACT    = 2,
  parameter int TICK_DIV   = 12000,
  parameter int TSW        = 16,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic [N_CH*W-1:0]    cur_in,
  input  logic [N_CH*VW-1:0]   th_in,
  output logic [N_CH-1:0]      spike,
  output logic [N_CH*VW-1:0]   vmem_out,
  output logic                 ev_valid,
  output logic [3:0]           ev_ch,
  output logic [TSW-1:0]       ev_ts,
  input  logic                 ev_ready,
  output logic                 ovf,
  input  logic                 ovf_clr,
  output logic                 busy
);

  localparam int c_CW = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int c_DW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int c_RW = (REFRACT > 0) ? $clog2(REFRACT + 1) : 1;
  localparam int c_AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  localparam logic [0:0] c_IDLE = 1'b0;
  localparam logic [0:0] c_SCAN = 1'b1;

  // ---------------------------------------------------------------------------
  // Tick divider and timestamp
  // ---------------------------------------------------------------------------
  logic [c_DW-1:0] r_div_cnt;
  logic [TSW-1:0]  r_ts;
  logic            w_tick;

  assign w_tick = en && (r_div_cnt == c_DW'(TICK_DIV - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_div_cnt <= '0;
      r_ts      <= '0;
    end else begin
      if (!en || w_tick) begin
        r_div_cnt <= '0;
      end else begin
        r_div_cnt <= r_div_cnt + 1'b1;
      end
      if (w_tick) begin
        r_ts <= r_ts + 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Scan FSM
  // ---------------------------------------------------------------------------
  logic [0:0]      r_state;
  logic [c_CW-1:0] r_ch_idx;
  logic            w_scan;

  assign w_scan = (r_state == c_SCAN);
  assign busy   = w_scan;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= c_IDLE;
      r_ch_idx <= '0;
    end else begin
      case (r_state)
        c_IDLE: begin
          if (w_tick) begin
            r_state  <= c_SCAN;
            r_ch_idx <= '0;
          end
        end
        c_SCAN: begin
          if (r_ch_idx == c_CW'(N_CH - 1)) begin
            r_state  <= c_IDLE;
            r_ch_idx <= '0;
          end else begin
            r_ch_idx <= r_ch_idx + 1'b1;
          end
        end
        default: begin
          r_state  <= c_IDLE;
          r_ch_idx <= '0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Shared channel update datapath (one channel per scan cycle)
  // ---------------------------------------------------------------------------
  logic [VW-1:0]   r_v    [N_CH];
  logic [c_RW-1:0] r_rcnt [N_CH];
  logic [N_CH-1:0] r_spike;

  logic [VW-1:0]   w_v_cur;
  logic [c_RW-1:0] w_rc_cur;
  logic [W-1:0]    w_cur;
  logic [VW-1:0]   w_th;
  logic [VW:0]     w_sum;
  logic [VW-1:0]   w_vn;
  logic [VW-1:0]   w_v_nxt;
  logic [c_RW-1:0] w_rc_nxt;
  logic            w_fire;

  always_comb begin
    w_v_cur  = r_v[r_ch_idx];
    w_rc_cur = r_rcnt[r_ch_idx];
    w_cur    = cur_in[r_ch_idx*W +: W];
    w_th     = th_in[r_ch_idx*VW +: VW];
    // One spare bit catches the carry so the result can saturate.
    w_sum    = {1'b0, w_v_cur} - ({1'b0, w_v_cur} >> LEAK_SHIFT) + (VW+1)'(w_cur);
    w_vn     = w_sum[VW] ? {VW{1'b1}} : w_sum[VW-1:0];
    w_v_nxt  = w_vn;
    w_rc_nxt = '0;
    w_fire   = 1'b0;
    if (w_th == '0) begin
      w_v_nxt  = '0;
      w_rc_nxt = '0;
    end else if (w_rc_cur != '0) begin
      w_v_nxt  = '0;
      w_rc_nxt = w_rc_cur - 1'b1;
    end else if (w_vn >= w_th) begin
      w_fire   = 1'b1;
      w_v_nxt  = '0;
      w_rc_nxt = c_RW'(REFRACT);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < N_CH; k++) begin
        r_v[k]    <= '0;
        r_rcnt[k] <= '0;
      end
      r_spike <= '0;
    end else begin
      r_spike <= '0;
      if (w_scan) begin
        r_v[r_ch_idx]    <= w_v_nxt;
        r_rcnt[r_ch_idx] <= w_rc_nxt;
        if (w_fire) begin
          r_spike[r_ch_idx] <= 1'b1;
        end
      end
    end
  end

  assign spike = r_spike;

  generate
    for (genvar k = 0; k < N_CH; k++) begin : g_vmem
      assign vmem_out[k*VW +: VW] = r_v[k];
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Event FIFO; pointers carry an extra wrap bit to tell full from empty
  // ---------------------------------------------------------------------------
  logic [3:0]     r_mem_ch [FIFO_DEPTH];
  logic [TSW-1:0] r_mem_ts [FIFO_DEPTH];
  logic [c_AW:0]  r_wr_ptr;
  logic [c_AW:0]  r_rd_ptr;
  logic           r_ovf;

  logic           w_empty;
  logic           w_full;
  logic           w_push;
  logic           w_pop;
  logic           w_push_ok;
  logic           w_drop;

  assign w_empty   = (r_wr_ptr == r_rd_ptr);
  assign w_full    = ((r_wr_ptr - r_rd_ptr) == (c_AW+1)'(FIFO_DEPTH));
  assign w_push    = w_scan && w_fire;
  assign w_pop     = !w_empty && ev_ready;
  // A full FIFO still takes the event when the head leaves in the same cycle.
  assign w_push_ok = w_push && (!w_full || w_pop);
  assign w_drop    = w_push && w_full && !w_pop;

  always_ff @(posedge clk) begin
    if (w_push_ok) begin
      r_mem_ch[r_wr_ptr[c_AW-1:0]] <= 4'(r_ch_idx);
      r_mem_ts[r_wr_ptr[c_AW-1:0]] <= r_ts;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_ovf    <= 1'b0;
    end else begin
      if (w_push_ok) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      if (w_drop) begin
        r_ovf <= 1'b1;
      end else if (ovf_clr) begin
        r_ovf <= 1'b0;
      end
    end
  end

  assign ev_valid = !w_empty;
  assign ev_ch    = w_empty ? 4'd0 : r_mem_ch[r_rd_ptr[c_AW-1:0]];
  assign ev_ts    = w_empty ? '0 : r_mem_ts[r_rd_ptr[c_AW-1:0]];
  assign ovf      = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_lif_array.sv
`default_nettype none
// ============================================================================
// Module   : tb_lif_array
// Purpose  : Directed self-checking bench for lif_array (hand-computed vectors).
// Revision : 1.0 - initial release
// ============================================================================
module tb_lif_array;

  localparam int N_CH = 4;
  localparam int W    = 8;
  localparam int VW   = 12;
  localparam int TSW  = 16;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 en;
  logic [N_CH*W-1:0]    cur_in;
  logic [N_CH*VW-1:0]   th_in;
  logic [N_CH-1:0]      spike;
  logic [N_CH*VW-1:0]   vmem_out;
  logic                 ev_valid;
  logic [3:0]           ev_ch;
  logic [TSW-1:0]       ev_ts;
  logic                 ev_ready;
  logic                 ovf;
  logic                 ovf_clr;
  logic                 busy;

  int n_vec = 0;
  int n_err = 0;
  logic [N_CH-1:0] cap [0:N_CH];
  logic [N_CH-1:0] spk_or;

  lif_array #(
    .N_CH(N_CH), .W(W), .VW(VW), .LEAK_SHIFT(4), .REFRACT(2),
    .TICK_DIV(16), .TSW(TSW), .FIFO_DEPTH(4)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .cur_in(cur_in), .th_in(th_in),
    .spike(spike), .vmem_out(vmem_out), .ev_valid(ev_valid), .ev_ch(ev_ch),
    .ev_ts(ev_ts), .ev_ready(ev_ready), .ovf(ovf), .ovf_clr(ovf_clr),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [VW-1:0] vm(input int k);
    return vmem_out[k*VW +: VW];
  endfunction

  task automatic wait_busy(input logic lvl);
    int t = 0;
    while (busy !== lvl && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk("busy_wait", 32'(busy), 32'(lvl));
  endtask

  // Waits for the next scan and records spike[] from its first cycle onward.
  task automatic run_scan();
    wait_busy(1'b1);
    spk_or = '0;
    for (int j = 0; j <= N_CH; j++) begin
      cap[j] = spike;
      spk_or = spk_or | spike;
      @(negedge clk);
    end
    chk("scan_end", 32'(busy), 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic pop_check(input int ch, input int ts);
    chk("pop_valid", 32'(ev_valid), 32'd1);
    chk("pop_ch", 32'(ev_ch), 32'(ch));
    chk("pop_ts", 32'(ev_ts), 32'(ts));
    ev_ready = 1'b1;
    @(negedge clk);
    ev_ready = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int bcnt;
    logic [VW-1:0] lk_exp [0:2];
    lk_exp[0] = 12'd100;
    lk_exp[1] = 12'd194;
    lk_exp[2] = 12'd282;
    rst = 1'b1; en = 1'b0; ev_ready = 1'b0; ovf_clr = 1'b0;
    cur_in = '0; th_in = '0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_valid", 32'(ev_valid), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    chk("rst_spike", 32'(spike), 32'd0);
    chk("rst_vmem", 32'(|vmem_out), 32'd0);
    chk("rst_evts", 32'(ev_ts), 32'd0);

    // Leak only; channel 2 disabled despite full-scale current
    cur_in = {8'd0, 8'd255, 8'd0, 8'd100};
    th_in  = {12'd0, 12'd0, 12'd0, 12'd4095};
    rst = 1'b0; en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      run_scan();
      chk("leak_v0", 32'(vm(0)), 32'(lk_exp[i]));
      chk("leak_nospk", 32'(spk_or), 32'd0);
    end
    chk("dis_v2", 32'(vm(2)), 32'd0);
    chk("dis_noev", 32'(ev_valid), 32'd0);

    // Spike and refractory
    cur_in = {8'd0, 8'd0, 8'd0, 8'd100};
    th_in  = {12'd0, 12'd0, 12'd0, 12'd250};
    do_reset();
    run_scan();
    run_scan();
    chk("ref_v0_t2", 32'(vm(0)), 32'd194);
    run_scan();
    chk("ref_spk_t3", 32'(cap[1]), 32'd1);
    chk("ref_spkor_t3", 32'(spk_or), 32'd1);
    chk("ref_v0_t3", 32'(vm(0)), 32'd0);
    chk("ref_ev_valid", 32'(ev_valid), 32'd1);
    chk("ref_ev_ch", 32'(ev_ch), 32'd0);
    chk("ref_ev_ts", 32'(ev_ts), 32'd3);
    for (int i = 0; i < 2; i++) begin
      run_scan();
      chk("ref_v0_quiet", 32'(vm(0)), 32'd0);
      chk("ref_nospk", 32'(spk_or), 32'd0);
    end
    run_scan();
    chk("ref_v0_t6", 32'(vm(0)), 32'd100);
    ev_ready = 1'b1;
    @(negedge clk);
    ev_ready = 1'b0;
    chk("ref_popped", 32'(ev_valid), 32'd0);

    // Simultaneous spikes, then overflow with the consumer stalled
    cur_in = {4{8'd255}};
    th_in  = {4{12'd200}};
    do_reset();
    run_scan();
    for (int j = 0; j <= N_CH; j++) begin
      chk("sim_spk_seq", 32'(cap[j]), (j == 0) ? 32'd0 : (32'd1 << (j - 1)));
    end
    chk("sim_head_ch", 32'(ev_ch), 32'd0);
    chk("sim_head_ts", 32'(ev_ts), 32'd1);
    run_scan();
    run_scan();
    chk("ovf_before", 32'(ovf), 32'd0);
    run_scan();
    chk("ovf_t4_spk", 32'(spk_or), 32'hF);
    chk("ovf_set", 32'(ovf), 32'd1);
    for (int i = 0; i < N_CH; i++) pop_check(i, 1);
    chk("ovf_drained", 32'(ev_valid), 32'd0);
    chk("ovf_sticky", 32'(ovf), 32'd1);
    ovf_clr = 1'b1;
    @(negedge clk);
    ovf_clr = 1'b0;
    chk("ovf_clr", 32'(ovf), 32'd0);
    for (int i = 0; i < 5; i++) run_scan();
    chk("full_head_ts", 32'(ev_ts), 32'd7);

    // Tick 10: pop coincides with the channel-0 push into a full FIFO
    wait_busy(1'b1);
    ev_ready = 1'b1;
    @(negedge clk);
    ev_ready = 1'b0;
    wait_busy(1'b0);
    chk("pp_ovf", 32'(ovf), 32'd1);
    pop_check(1, 7);
    pop_check(2, 7);
    pop_check(3, 7);
    pop_check(0, 10);
    chk("pp_empty", 32'(ev_valid), 32'd0);

    // Asynchronous reset in the middle of the tick-13 scan
    run_scan();
    run_scan();
    wait_busy(1'b1);
    @(negedge clk);
    chk("ar_pre_spk", 32'(spike), 32'd1);
    chk("ar_pre_valid", 32'(ev_valid), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("ar_spike", 32'(spike), 32'd0);
    chk("ar_busy", 32'(busy), 32'd0);
    chk("ar_valid", 32'(ev_valid), 32'd0);
    chk("ar_ovf", 32'(ovf), 32'd0);
    chk("ar_evts", 32'(ev_ts), 32'd0);
    chk("ar_evch", 32'(ev_ch), 32'd0);
    chk("ar_vmem", 32'(|vmem_out), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    run_scan();
    chk("ar_first_ts", 32'(ev_ts), 32'd1);
    chk("ar_first_ch", 32'(ev_ch), 32'd0);

    // en dropped during a scan: scan completes, no more ticks, ts held
    cur_in = {8'd40, 8'd30, 8'd20, 8'd10};
    th_in  = {4{12'd4095}};
    do_reset();
    wait_busy(1'b1);
    en = 1'b0;
    wait_busy(1'b0);
    chk("en_v0", 32'(vm(0)), 32'd10);
    chk("en_v1", 32'(vm(1)), 32'd20);
    chk("en_v2", 32'(vm(2)), 32'd30);
    chk("en_v3", 32'(vm(3)), 32'd40);
    th_in[VW-1:0] = 12'd1;
    bcnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (busy) bcnt++;
    end
    chk("en_no_tick", 32'(bcnt), 32'd0);
    chk("en_noev", 32'(ev_valid), 32'd0);
    en = 1'b1;
    run_scan();
    chk("en_ts_held", 32'(ev_ts), 32'd2);
    chk("en_ev_ch", 32'(ev_ch), 32'd0);
    chk("en_v1_t2", 32'(vm(1)), 32'd39);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
